// File: rtl/upsp_stream_adapter_if.sv
// Stream bundle between the up-sampling adapter, the ac read/write ports and
// the up-sampling core. The master modport is the adapter's view.
interface upsp_stream_adapter_if #(
   parameter int PIX_WIDTH = 24,
   parameter int RD_PIX    = 4,
   parameter int WR_PIX    = 4
);
   // ac read beats into the adapter
   logic                          ac_upsp_rvalid;
   logic [RD_PIX*PIX_WIDTH-1:0]   ac_upsp_rdata;
   logic                          upsp_ac_rready;
   // one pixel per beat towards the core
   logic                          adp_core_valid;
   logic [PIX_WIDTH-1:0]          adp_core_pixel;
   logic                          core_adp_ready;
   // one pixel per beat from the core
   logic                          core_adp_valid;
   logic [PIX_WIDTH-1:0]          core_adp_pixel;
   logic                          adp_core_ready;
   // packed ac write beats out of the adapter
   logic                          upsp_ac_wvalid;
   logic [WR_PIX*PIX_WIDTH-1:0]   upsp_ac_wdata;
   logic                          upsp_ac_wlast;
   logic                          ac_upsp_wready;

   modport master (
      input  ac_upsp_rvalid, ac_upsp_rdata, core_adp_ready,
      input  core_adp_valid, core_adp_pixel, ac_upsp_wready,
      output upsp_ac_rready, adp_core_valid, adp_core_pixel,
      output adp_core_ready, upsp_ac_wvalid, upsp_ac_wdata, upsp_ac_wlast
   );

   modport slave (
      output ac_upsp_rvalid, ac_upsp_rdata, core_adp_ready,
      output core_adp_valid, core_adp_pixel, ac_upsp_wready,
      input  upsp_ac_rready, adp_core_valid, adp_core_pixel,
      input  adp_core_ready, upsp_ac_wvalid, upsp_ac_wdata, upsp_ac_wlast
   );
endinterface

// File: rtl/upsp_stream_adapter.sv
// Frame-level adapter: unpacks wide ac read beats into a pixel stream for the
// up-sampling core, packs core pixels back into wide ac write beats, and
// sequences a frame from UPSTR (start edge / abort level) with status on UPENDR.
module upsp_stream_adapter #(
   parameter int CRF_DATA_WIDTH = 32,
   parameter int PIX_WIDTH      = 24,
   parameter int RD_PIX         = 4,
   parameter int WR_PIX         = 4,
   parameter int CNT_W          = 24
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CRF_DATA_WIDTH-1:0] UPSTR,
   output logic [CRF_DATA_WIDTH-1:0] UPENDR,
   input  logic [CNT_W-1:0]          cfg_in_pix,
   input  logic [CNT_W-1:0]          cfg_out_pix,
   upsp_stream_adapter_if.master     bus
);
   localparam int LANE_W = $clog2(RD_PIX + 1);
   localparam int PACK_W = (WR_PIX > 1) ? $clog2(WR_PIX) : 1;
   localparam int RD_W   = RD_PIX * PIX_WIDTH;
   localparam int WR_W   = WR_PIX * PIX_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // frame sequencing
   state_t                state_reg;
   logic                  start_prev_reg;
   logic [2:0]            status_reg;

   // read side: pixels still to be fetched, pixels still to be handed to core
   logic [CNT_W-1:0]      in_req_rem_reg;
   logic [CNT_W-1:0]      in_pix_rem_reg;
   logic [RD_W-1:0]       beat_reg;
   logic [LANE_W-1:0]     lanes_left_reg;
   logic                  core_valid_reg;

   // write side
   logic [CNT_W-1:0]      out_pix_rem_reg;
   logic [WR_W-1:0]       pack_reg;
   logic [WR_W-1:0]       pack_next;
   logic [PACK_W-1:0]     pack_cnt_reg;
   logic                  wvalid_reg;
   logic [WR_W-1:0]       wdata_reg;
   logic                  wlast_reg;
   logic                  wlast_sent_reg;

   // control decode
   logic                  active;
   logic                  abort_now;
   logic                  start_edge;
   logic                  start_now;
   logic                  cfg_bad;
   logic                  start_ok;
   logic                  core_fire;
   logic                  last_lane_fire;
   logic                  rready;
   logic                  rd_fire;
   logic [LANE_W-1:0]     take;
   logic                  core_ready;
   logic                  out_fire;
   logic                  w_fire;
   logic                  final_px;
   logic                  pack_full;
   logic                  emit_beat;
   logic                  in_done;
   logic                  wlast_done;
   logic                  unused_upstr;

   assign unused_upstr = ^UPSTR[CRF_DATA_WIDTH-1:2];

   assign active     = (state_reg == RUN) || (state_reg == DRAIN);
   assign abort_now  = active && UPSTR[1];
   assign start_edge = UPSTR[0] && !start_prev_reg;
   // abort level also masks a start edge arriving in the same cycle
   assign start_now  = (state_reg == IDLE) && start_edge && !UPSTR[1];
   assign cfg_bad    = (cfg_in_pix == '0) || (cfg_out_pix == '0);
   assign start_ok   = start_now && !cfg_bad;

   // read handshakes: a new beat may be taken while the last buffered lane leaves
   assign core_fire      = core_valid_reg && bus.core_adp_ready;
   assign last_lane_fire = core_fire && (lanes_left_reg == LANE_W'(1));
   assign rready         = active && !abort_now && (in_req_rem_reg != '0) &&
                           ((lanes_left_reg == '0) || last_lane_fire);
   assign rd_fire        = rready && bus.ac_upsp_rvalid;
   // a short final beat only exposes the lanes that belong to the frame
   assign take           = (in_req_rem_reg >= CNT_W'(RD_PIX)) ? LANE_W'(RD_PIX)
                                                              : in_req_rem_reg[LANE_W-1:0];

   // write handshakes: core is held off only while a beat is stuck at the output
   assign core_ready = active && !abort_now && (out_pix_rem_reg != '0) &&
                       !(wvalid_reg && !bus.ac_upsp_wready);
   assign out_fire   = bus.core_adp_valid && core_ready;
   assign w_fire     = wvalid_reg && bus.ac_upsp_wready;
   assign final_px   = (out_pix_rem_reg == CNT_W'(1));
   assign pack_full  = (pack_cnt_reg == PACK_W'(WR_PIX - 1));
   assign emit_beat  = out_fire && (pack_full || final_px);

   // completion terms include same-cycle events so DONE follows the last handshake directly
   assign in_done    = (in_pix_rem_reg == '0) ||
                       ((in_pix_rem_reg == CNT_W'(1)) && core_fire);
   assign wlast_done = wlast_sent_reg || (w_fire && wlast_reg);

   // drop the incoming core pixel into its pack lane; other lanes keep their value
   for (genvar gi = 0; gi < WR_PIX; gi++) begin : g_pack
      assign pack_next[gi*PIX_WIDTH +: PIX_WIDTH] =
         (pack_cnt_reg == PACK_W'(gi)) ? bus.core_adp_pixel
                                       : pack_reg[gi*PIX_WIDTH +: PIX_WIDTH];
   end

   assign bus.upsp_ac_rready = rready;
   assign bus.adp_core_valid = core_valid_reg;
   assign bus.adp_core_pixel = beat_reg[PIX_WIDTH-1:0];
   assign bus.adp_core_ready = core_ready;
   assign bus.upsp_ac_wvalid = wvalid_reg;
   assign bus.upsp_ac_wdata  = wdata_reg;
   assign bus.upsp_ac_wlast  = wlast_reg;
   assign UPENDR             = {{(CRF_DATA_WIDTH-3){1'b0}}, status_reg};

   // read side: load a beat, then shift it down one lane per core handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_req_rem_reg <= '0;
         in_pix_rem_reg <= '0;
         beat_reg       <= '0;
         lanes_left_reg <= '0;
         core_valid_reg <= 1'b0;
      end else if (abort_now) begin
         in_req_rem_reg <= '0;
         in_pix_rem_reg <= '0;
         beat_reg       <= '0;
         lanes_left_reg <= '0;
         core_valid_reg <= 1'b0;
      end else if (start_ok) begin
         in_req_rem_reg <= cfg_in_pix;
         in_pix_rem_reg <= cfg_in_pix;
         beat_reg       <= '0;
         lanes_left_reg <= '0;
         core_valid_reg <= 1'b0;
      end else begin
         if (rd_fire) begin
            beat_reg       <= bus.ac_upsp_rdata;
            lanes_left_reg <= take;
            core_valid_reg <= 1'b1;
            in_req_rem_reg <= in_req_rem_reg - CNT_W'(take);
         end else if (core_fire) begin
            beat_reg       <= beat_reg >> PIX_WIDTH;
            lanes_left_reg <= lanes_left_reg - LANE_W'(1);
            core_valid_reg <= (lanes_left_reg != LANE_W'(1));
         end
         if (core_fire) begin
            in_pix_rem_reg <= in_pix_rem_reg - CNT_W'(1);
         end
      end
   end

   // write side: fill pack lanes, hand a full or final pack to the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pix_rem_reg <= '0;
         pack_reg        <= '0;
         pack_cnt_reg    <= '0;
         wvalid_reg      <= 1'b0;
         wdata_reg       <= '0;
         wlast_reg       <= 1'b0;
         wlast_sent_reg  <= 1'b0;
      end else if (abort_now || start_ok) begin
         out_pix_rem_reg <= start_ok ? cfg_out_pix : '0;
         pack_reg        <= '0;
         pack_cnt_reg    <= '0;
         wvalid_reg      <= 1'b0;
         wdata_reg       <= '0;
         wlast_reg       <= 1'b0;
         wlast_sent_reg  <= 1'b0;
      end else begin
         if (out_fire) begin
            out_pix_rem_reg <= out_pix_rem_reg - CNT_W'(1);
            if (emit_beat) begin
               pack_reg     <= '0;
               pack_cnt_reg <= '0;
            end else begin
               pack_reg     <= pack_next;
               pack_cnt_reg <= pack_cnt_reg + PACK_W'(1);
            end
         end
         if (emit_beat) begin
            wvalid_reg <= 1'b1;
            wdata_reg  <= pack_next;
            wlast_reg  <= final_px;
         end else if (w_fire) begin
            wvalid_reg <= 1'b0;
            wdata_reg  <= '0;
            wlast_reg  <= 1'b0;
         end
         if (w_fire && wlast_reg) begin
            wlast_sent_reg <= 1'b1;
         end
      end
   end

   // frame FSM with sticky status register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         start_prev_reg <= 1'b0;
         status_reg     <= 3'b000;
      end else begin
         start_prev_reg <= UPSTR[0];
         case (state_reg)
            IDLE: begin
               if (start_now) begin
                  if (cfg_bad) begin
                     status_reg <= 3'b100;
                  end else begin
                     status_reg <= 3'b000;
                     state_reg  <= RUN;
                  end
               end
            end
            RUN: begin
               if (abort_now) begin
                  status_reg <= 3'b010;
                  state_reg  <= IDLE;
               end else if (out_fire && final_px) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (abort_now) begin
                  status_reg <= 3'b010;
                  state_reg  <= IDLE;
               end else if (wlast_done && in_done) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               status_reg <= 3'b001;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_upsp_stream_adapter.sv
// Scoreboard bench for upsp_stream_adapter: an ac read source, a core model
// emitting four pixels per input pixel, and an ac write sink that checks beats.
module tb_upsp_stream_adapter;
   localparam int PW = 24;
   localparam int RP = 4;
   localparam int WP = 4;
   localparam int CW = 24;
   localparam int DW = 32;

   typedef struct packed {
      logic [WP*PW-1:0] data;
      logic             last;
   } wbeat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] upstr = '0;
   wire  [DW-1:0] upendr;
   logic [CW-1:0] cfg_in = '0;
   logic [CW-1:0] cfg_out = '0;

   upsp_stream_adapter_if #(.PIX_WIDTH(PW), .RD_PIX(RP), .WR_PIX(WP)) bus ();

   upsp_stream_adapter #(
      .CRF_DATA_WIDTH(DW), .PIX_WIDTH(PW), .RD_PIX(RP), .WR_PIX(WP), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .UPSTR(upstr),
      .UPENDR(upendr),
      .cfg_in_pix(cfg_in),
      .cfg_out_pix(cfg_out),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int frame_no = 0;
   int rd_beats = 0;
   int w_cnt = 0;
   int last_w_edge = 0;
   int stall_seen = 0;
   logic stall_req = 1'b0;

   logic [RP*PW-1:0] src_q[$];
   logic [PW-1:0]    exp_core_q[$];
   logic [PW-1:0]    core_out_q[$];
   wbeat_t           exp_w_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // ac read source: offers queued beats, pops on handshake
   initial begin
      logic rd_hs;
      bus.ac_upsp_rvalid = 1'b0;
      bus.ac_upsp_rdata  = '0;
      forever begin
         @(negedge clk);
         rd_hs = bus.ac_upsp_rvalid && bus.upsp_ac_rready;
         @(posedge clk); #1;
         if (rd_hs && src_q.size() > 0) begin
            src_q.delete(0);
            rd_beats++;
         end
         if (src_q.size() > 0) begin
            bus.ac_upsp_rvalid = 1'b1;
            bus.ac_upsp_rdata  = src_q[0];
         end else begin
            bus.ac_upsp_rvalid = 1'b0;
            bus.ac_upsp_rdata  = '0;
         end
      end
   end

   // core input: checks each pixel in lane order, queues four derived outputs
   initial begin
      logic [PW-1:0] px;
      bus.core_adp_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.adp_core_valid && bus.core_adp_ready) begin
            px = bus.adp_core_pixel;
            if (exp_core_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL core_pixel: got %h required no pixel", px);
            end else begin
               check("core_pixel", px, exp_core_q[0]);
               exp_core_q.delete(0);
            end
            for (int c = 0; c < 4; c++) core_out_q.push_back(px + PW'(c));
         end
         @(posedge clk); #1;
         bus.core_adp_ready = (cyc % 5) != 4;
      end
   end

   // core output: presents queued pixels, holds each until accepted
   initial begin
      logic c_hs;
      bus.core_adp_valid = 1'b0;
      bus.core_adp_pixel = '0;
      forever begin
         @(negedge clk);
         c_hs = bus.core_adp_valid && bus.adp_core_ready;
         @(posedge clk); #1;
         if (c_hs && core_out_q.size() > 0) core_out_q.delete(0);
         if (core_out_q.size() > 0) begin
            bus.core_adp_valid = 1'b1;
            bus.core_adp_pixel = core_out_q[0];
         end else begin
            bus.core_adp_valid = 1'b0;
            bus.core_adp_pixel = '0;
         end
      end
   end

   // ac write sink: compares beats, optionally stalls wready across 10 valid cycles
   initial begin
      logic [WP*PW-1:0] held_data;
      logic             held_last;
      held_data = '0;
      held_last = 1'b0;
      bus.ac_upsp_wready = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.upsp_ac_wvalid && bus.ac_upsp_wready) begin
            w_cnt++;
            $display("write beat %0d frame %0d: data=%h last=%0b", w_cnt, frame_no,
                     bus.upsp_ac_wdata, bus.upsp_ac_wlast);
            if (exp_w_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL wbeat: got %h required no beat", bus.upsp_ac_wdata);
            end else begin
               check("wdata", bus.upsp_ac_wdata, exp_w_q[0].data);
               check("wlast", bus.upsp_ac_wlast, exp_w_q[0].last);
               exp_w_q.delete(0);
            end
            if (bus.upsp_ac_wlast) last_w_edge = cyc + 1;
         end
         if (stall_req && !bus.ac_upsp_wready && bus.upsp_ac_wvalid) begin
            if (stall_seen == 0) begin
               held_data = bus.upsp_ac_wdata;
               held_last = bus.upsp_ac_wlast;
            end else begin
               check("stall_wdata", bus.upsp_ac_wdata, held_data);
               check("stall_wlast", bus.upsp_ac_wlast, held_last);
            end
            check("stall_core_ready", bus.adp_core_ready, 1'b0);
            stall_seen++;
         end
         @(posedge clk); #1;
         if (stall_req) begin
            if (stall_seen >= 10) begin
               stall_req = 1'b0;
               stall_seen = 0;
               bus.ac_upsp_wready = 1'b1;
            end else begin
               bus.ac_upsp_wready = 1'b0;
            end
         end
      end
   end

   task automatic flush_all();
      @(posedge clk); #2;
      src_q.delete();
      exp_core_q.delete();
      core_out_q.delete();
      exp_w_q.delete();
   endtask

   // builds source beats and expected results, then pulses the start bit
   task automatic start_frame(input int n_in, input int n_out, input int extra);
      logic [PW-1:0]    in_px[$];
      logic [RP*PW-1:0] beat;
      wbeat_t           wb;
      int               idx;
      frame_no++;
      @(posedge clk); #2;
      rd_beats = 0;
      w_cnt = 0;
      for (int i = 0; i < n_in; i++) begin
         in_px.push_back(PW'(frame_no << 16) | PW'(i << 4));
         exp_core_q.push_back(PW'(frame_no << 16) | PW'(i << 4));
      end
      for (int b = 0; b < (n_in + RP - 1) / RP + extra; b++) begin
         beat = '0;
         for (int l = 0; l < RP; l++) begin
            idx = b * RP + l;
            if (idx < n_in) beat[l*PW +: PW] = in_px[idx];
            else            beat[l*PW +: PW] = PW'(24'hBAD000 + idx);
         end
         src_q.push_back(beat);
      end
      for (int b = 0; b * WP < n_out; b++) begin
         wb.data = '0;
         for (int l = 0; l < WP; l++) begin
            idx = b * WP + l;
            if (idx < n_out) wb.data[l*PW +: PW] = in_px[idx / 4] + PW'(idx % 4);
         end
         wb.last = ((b + 1) * WP >= n_out);
         exp_w_q.push_back(wb);
      end
      cfg_in  = CW'(n_in);
      cfg_out = CW'(n_out);
      upstr[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1 upstr[0] = 1'b0;
   endtask

   // waits for completion and checks status, latency and scoreboard drain
   task automatic finish_frame(input int exp_rd_beats, input string name);
      int t;
      t = 0;
      while (upendr == '0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: got no UPENDR status required 0x1", name);
      end
      check({name, "_upendr"}, upendr, 32'h1);
      check({name, "_done_latency"}, cyc - last_w_edge, 1);
      check({name, "_core_left"}, exp_core_q.size(), 0);
      check({name, "_wbeats_left"}, exp_w_q.size(), 0);
      repeat (4) @(negedge clk);
      check({name, "_rd_beats"}, rd_beats, exp_rd_beats);
      check({name, "_rready_idle"}, bus.upsp_ac_rready, 1'b0);
      flush_all();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_upendr", upendr, 32'h0);
      check("rst_rready", bus.upsp_ac_rready, 1'b0);
      check("rst_core_valid", bus.adp_core_valid, 1'b0);
      check("rst_core_ready", bus.adp_core_ready, 1'b0);
      check("rst_wvalid", bus.upsp_ac_wvalid, 1'b0);
      check("rst_wdata", bus.upsp_ac_wdata, '0);
      check("rst_wlast", bus.upsp_ac_wlast, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // 8 in -> 32 out: 2 read beats, 8 write beats, wlast on the 8th only
      start_frame(8, 32, 0);
      finish_frame(2, "basic");

      // 6 in: short second beat, extra beat offered but never taken
      start_frame(6, 24, 1);
      finish_frame(2, "short_in");

      // 30 out: final beat half filled and zero padded
      start_frame(8, 30, 0);
      finish_frame(2, "short_out");

      // write backpressure for 10 valid cycles
      @(posedge clk); #2 stall_req = 1'b1;
      start_frame(8, 32, 0);
      finish_frame(2, "stall");
      check("stall_released", stall_req, 1'b0);

      // abort after 3 write beats, then a clean frame
      start_frame(8, 32, 0);
      t = 0;
      while (w_cnt < 3 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("abort_reached_3_beats", w_cnt >= 3, 1'b1);
      @(posedge clk); #1 upstr[1] = 1'b1;
      @(posedge clk); #1 upstr[1] = 1'b0;
      @(negedge clk);
      check("abort_upendr", upendr, 32'h2);
      check("abort_rready", bus.upsp_ac_rready, 1'b0);
      check("abort_core_valid", bus.adp_core_valid, 1'b0);
      check("abort_core_ready", bus.adp_core_ready, 1'b0);
      check("abort_wvalid", bus.upsp_ac_wvalid, 1'b0);
      flush_all();
      start_frame(8, 32, 0);
      finish_frame(2, "after_abort");

      // zero output count: cfg error, no reads
      frame_no++;
      @(posedge clk); #2;
      rd_beats = 0;
      src_q.push_back({RP*PW{1'b1}});
      cfg_in  = CW'(8);
      cfg_out = '0;
      upstr[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1 upstr[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("cfgerr_rready", bus.upsp_ac_rready, 1'b0);
      end
      check("cfgerr_upendr", upendr, 32'h4);
      check("cfgerr_rd_beats", rd_beats, 0);
      flush_all();

      // second start edge while running must not reload the counts
      start_frame(8, 32, 0);
      repeat (10) @(posedge clk);
      #2;
      cfg_in  = CW'(4);
      cfg_out = CW'(4);
      upstr[0] = 1'b1;
      @(posedge clk); #1 upstr[0] = 1'b0;
      finish_frame(2, "restart_ignored");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
